d_bounce_multi: RTL and testbench

//  - N-channel parametrised debouncer for slow mechanical inputs (keys, switches) on the 1 kHz domain.
//  - Each channel commits a new level only after STABLE_TIME consecutive identical samples.
//  - Each channel reports a one-cycle rise/fall pulse, a settling flag, and an aggregate change pulse.
//  - Sits between raw pad inputs and control FSMs; successor of the single-channel debouncer.

---
 rtl/d_bounce_pkg.sv | 7 +
 rtl/d_bounce_multi_if.sv | 11 +
 rtl/d_bounce_ch.sv | 67 ++++++
 rtl/d_bounce_multi.sv | 27 ++
 tb/tb_d_bounce_multi.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/d_bounce_pkg.sv
// d_bounce_pkg: shared state type and counter sizing for the multi-channel debouncer
package d_bounce_pkg;
  typedef enum logic {ST_STABLE, ST_SETTLE} db_state_t;
  function automatic int db_cnt_w(input int stable_time);
    return $clog2(stable_time + 1);
  endfunction
endpackage

// File: rtl/d_bounce_multi_if.sv
// d_bounce_multi_if: raw inputs and debounced outputs of the multi-channel debouncer
interface d_bounce_multi_if #(parameter int NUM_CH = 4) ();
  logic [NUM_CH-1:0] data_in;
  logic [NUM_CH-1:0] data_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] settling;
  logic              change_any;
  modport master (output data_in, input data_out, rise_pulse, fall_pulse, settling, change_any);
  modport slave  (input data_in, output data_out, rise_pulse, fall_pulse, settling, change_any);
endinterface

// File: rtl/d_bounce_ch.sv
// d_bounce_ch: one debouncer channel; D_BOUNCE_SYNC_EN adds a 2-flop input synchroniser
module d_bounce_ch
  import d_bounce_pkg::*;
#(
  parameter int   STABLE_TIME = 10,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_1Khz,
  input  logic rst_n,
  input  logic data_in,
  output logic data_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic settling
);
  localparam int CW = db_cnt_w(STABLE_TIME);
  localparam logic [CW-1:0] CMAX  = CW'(STABLE_TIME);
  localparam logic [CW-1:0] CLAST = CW'(STABLE_TIME - 1);
  logic s;
`ifdef D_BOUNCE_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk_1Khz or negedge rst_n)
    if (!rst_n) sync <= {2{RESET_VAL}};
    else sync <= {sync[0], data_in};
  assign s = sync[1];
`else
  assign s = data_in;
`endif
  db_state_t state, state_nx;
  logic prev, prev_nx, dout_nx;
  logic [CW-1:0] cnt, cnt_nx;
  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    cnt_nx   = cnt;
    dout_nx  = data_out;
    if (s != prev) begin
      prev_nx  = s;
      cnt_nx   = '0;
      state_nx = ST_SETTLE;
    end else if (state == ST_SETTLE) begin
      if (cnt == CLAST) begin
        cnt_nx   = CMAX;
        state_nx = ST_STABLE;
        dout_nx  = prev;
      end else cnt_nx = cnt + 1'b1;
    end
  end
  // Pulses are registered alongside data_out so they coincide with the commit
  always_ff @(posedge clk_1Khz or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_STABLE;
      prev       <= RESET_VAL;
      cnt        <= CMAX;
      data_out   <= RESET_VAL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      cnt        <= cnt_nx;
      data_out   <= dout_nx;
      rise_pulse <= dout_nx & ~data_out;
      fall_pulse <= ~dout_nx & data_out;
    end
  assign settling = (state == ST_SETTLE);
endmodule

// File: rtl/d_bounce_multi.sv
// d_bounce_multi: N independent debouncer channels plus an aggregate change pulse (D_BOUNCE_SYNC_EN enables input sync)
module d_bounce_multi
  import d_bounce_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                STABLE_TIME = 10,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
  input logic             clk_1Khz,
  input logic             rst_n,
  d_bounce_multi_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    d_bounce_ch #(.STABLE_TIME(STABLE_TIME), .RESET_VAL(RESET_VAL[i])) u_ch (
      .clk_1Khz  (clk_1Khz),
      .rst_n     (rst_n),
      .data_in   (bus.data_in[i]),
      .data_out  (bus.data_out[i]),
      .rise_pulse(bus.rise_pulse[i]),
      .fall_pulse(bus.fall_pulse[i]),
      .settling  (bus.settling[i])
    );
  end
  always_ff @(posedge clk_1Khz or negedge rst_n)
    if (!rst_n) bus.change_any <= 1'b0;
    else bus.change_any <= |(bus.rise_pulse | bus.fall_pulse);
endmodule

// File: tb/tb_d_bounce_multi.sv
// tb_d_bounce_multi: directed stimulus with a pulse scoreboard for d_bounce_multi
module tb_d_bounce_multi;
`ifdef D_BOUNCE_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int LAT = 10 + SD;
  typedef struct {int cyc; logic [3:0] r; logic [3:0] f;} ev_t;
  logic clk_1Khz = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   tot_cnt = 0;
  int   exp_ca = -10;
  int   t;
  bit   mon_en = 1'b0;
  ev_t  sb[$];
  ev_t  e;
  d_bounce_multi_if #(.NUM_CH(4)) bus ();
  d_bounce_multi #(.NUM_CH(4), .STABLE_TIME(10), .RESET_VAL(4'b0000)) dut (
    .clk_1Khz(clk_1Khz),
    .rst_n   (rst_n),
    .bus     (bus)
  );
  always #5 clk_1Khz = ~clk_1Khz;
  always @(posedge clk_1Khz) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk_1Khz);
  endtask
  // Pulses are matched in order against the scoreboard; change_any must trail each matched pulse by one cycle
  always @(negedge clk_1Khz) if (mon_en) begin
    if ((bus.rise_pulse | bus.fall_pulse) != 4'b0) begin
      if (sb.size() == 0) chk("spurious_pulse", {24'b0, bus.rise_pulse, bus.fall_pulse}, 32'b0);
      else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("rise_pulse", bus.rise_pulse, e.r);
        chk("fall_pulse", bus.fall_pulse, e.f);
        exp_ca = cyc + 1;
      end
    end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missing_pulse", cyc, e.cyc);
    end
    chk("change_any", bus.change_any, cyc == exp_ca);
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b1;
    bus.data_in = 4'b0000;
    repeat (2) @(negedge clk_1Khz);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_rise", bus.rise_pulse, 0);
    chk("rst_fall", bus.fall_pulse, 0);
    chk("rst_settling", bus.settling, 0);
    chk("rst_change_any", bus.change_any, 0);
    mon_en = 1'b1;
    repeat (3) @(negedge clk_1Khz);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_1Khz);
      chk("idle_settling", bus.settling, 0);
      chk("idle_data_out", bus.data_out, 0);
    end
    bus.data_in[0] = 1'b1;
    t = cyc + 1;
    sb.push_back('{t + LAT, 4'b0001, 4'b0000});
    wait_cyc(t + SD);
    chk("rise_settling", bus.settling, 4'b0001);
    wait_cyc(t + LAT - 1);
    chk("rise_before_commit", bus.data_out, 4'b0000);
    wait_cyc(t + LAT);
    chk("rise_commit", bus.data_out, 4'b0001);
    wait_cyc(t + LAT + 1);
    chk("rise_pulse_gone", bus.rise_pulse, 0);
    chk("rise_settled", bus.settling, 0);
    for (int i = 0; i < 5; i++) begin
      bus.data_in[1] = ~i[0];
      t = cyc + 1;
      if (i == 4) sb.push_back('{t + LAT, 4'b0010, 4'b0000});
      repeat (3) @(negedge clk_1Khz);
      chk("bounce_hold", bus.data_out[1], 0);
    end
    wait_cyc(t + LAT - 1);
    chk("bounce_before_commit", bus.data_out[1], 0);
    wait_cyc(t + LAT);
    chk("bounce_commit", bus.data_out, 4'b0011);
    bus.data_in[2] = 1'b1;
    t = cyc + 1;
    sb.push_back('{t + LAT, 4'b0100, 4'b0000});
    wait_cyc(t + LAT + 2);
    chk("glitch_setup", bus.data_out, 4'b0111);
    bus.data_in[2] = 1'b0;
    repeat (4) @(negedge clk_1Khz);
    bus.data_in[2] = 1'b1;
    t = cyc + 1;
    chk("glitch_during", bus.data_out[2], 1);
    wait_cyc(t + LAT - 1);
    chk("glitch_settling", bus.settling[2], 1);
    wait_cyc(t + LAT);
    chk("glitch_settled", bus.settling[2], 0);
    chk("glitch_kept", bus.data_out, 4'b0111);
    bus.data_in[0] = 1'b0;
    t = cyc + 1;
    sb.push_back('{t + LAT, 4'b0000, 4'b0001});
    wait_cyc(t + LAT + 2);
    chk("fall_commit", bus.data_out, 4'b0110);
    bus.data_in = bus.data_in | 4'b1001;
    t = cyc + 1;
    sb.push_back('{t + LAT, 4'b1001, 4'b0000});
    wait_cyc(t + LAT);
    chk("simul_rise", bus.rise_pulse, 4'b1001);
    wait_cyc(t + LAT + 1);
    chk("simul_change_any", bus.change_any, 1);
    wait_cyc(t + LAT + 2);
    chk("simul_change_any_once", bus.change_any, 0);
    chk("simul_data_out", bus.data_out, 4'b1111);
    bus.data_in[1] = 1'b0;
    t = cyc + 1;
    wait_cyc(t + 5 + SD);
    chk("mid_settle", bus.settling, 4'b0010);
    #2 rst_n = 1'b0;
    bus.data_in = 4'b0000;
    #1;
    chk("mid_rst_data_out", bus.data_out, 0);
    chk("mid_rst_pulses", {bus.rise_pulse, bus.fall_pulse}, 0);
    chk("mid_rst_settling", bus.settling, 0);
    repeat (2) @(negedge clk_1Khz);
    rst_n = 1'b1;
    repeat (15 + SD) @(negedge clk_1Khz);
    chk("post_rst_data_out", bus.data_out, 0);
    chk("post_rst_settling", bus.settling, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
